// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and index sizing helper
// for the register-slave slice.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_RESP   = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axil_byte_regfile.sv
// NUM_REGS x DATA_WIDTH register storage with asynchronous clear, one
// byte-strobed write port and one combinational read port.
module axil_byte_regfile
    import axil_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 8,
    localparam int IDX_W      = idx_width(NUM_REGS),
    localparam int NUM_BYTES  = DATA_WIDTH / 8
) (
    input  logic                  clk_sys,
    input  logic                  rst_b,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_BYTES-1:0]  wr_strb,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register bank: independent AW/W capture, strobed commit,
// registered reads, SLVERR for addresses outside [BASE_ADDR, BASE_ADDR+size).
//
//   state    | meaning
//   W_ACCEPT | collecting AW and W into holding regs; commit once both held
//   W_RESP   | write done, holding bvalid/bresp until bready
//   R_IDLE   | arready high, waiting for an AR handshake
//   R_DATA   | holding rvalid/rdata/rresp until rready
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int                    NUM_BYTES    = DATA_WIDTH / 8;
    localparam int                    IDX_W        = idx_width(NUM_REGS);
    localparam int                    BYTE_SH      = $clog2(NUM_BYTES);
    localparam logic [31:0]           REGION_BYTES = 32'(NUM_REGS * NUM_BYTES);
    localparam logic [RESP_WIDTH-1:0] OKAY_R       = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR_R     = RESP_WIDTH'(RESP_SLVERR);

    // Offset is computed 32 bits wide so addresses below BASE_ADDR cannot
    // alias into the region after wrap-around.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] offset;
        offset = 32'(addr) - 32'(BASE_ADDR);
        return (addr >= BASE_ADDR) && (offset < REGION_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] offset;
        offset = 32'(addr) - 32'(BASE_ADDR);
        return IDX_W'(offset >> BYTE_SH);
    endfunction

    logic unused_strb_msb;
    assign unused_strb_msb = s_axi_wstrb[NUM_BYTES];

    wr_state_t             wr_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NUM_BYTES-1:0]  w_strb_q;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  commit;
    logic                  commit_hit;

    assign aw_fire    = s_axi_awvalid && s_axi_awready;
    assign w_fire     = s_axi_wvalid && s_axi_wready;
    assign commit     = (wr_state == W_ACCEPT) && aw_held && w_held;
    assign commit_hit = addr_hit(aw_addr_q);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state      <= W_ACCEPT;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= '0;
        end else begin
            case (wr_state)
                W_ACCEPT: begin
                    if (aw_fire) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= s_axi_awaddr;
                    end
                    if (w_fire) begin
                        w_held   <= 1'b1;
                        w_data_q <= s_axi_wdata;
                        w_strb_q <= s_axi_wstrb[NUM_BYTES-1:0];
                    end
                    if (commit) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= commit_hit ? OKAY_R : SLVERR_R;
                        wr_state      <= W_RESP;
                    end else begin
                        s_axi_awready <= !(aw_held || aw_fire);
                        s_axi_wready  <= !(w_held || w_fire);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wr_state      <= W_ACCEPT;
                    end
                end
            endcase
        end
    end

    rd_state_t             rd_state;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rf_rd_data;
    logic                  ar_fire;

    assign rd_idx  = addr_idx(s_axi_araddr);
    assign ar_fire = s_axi_arvalid && s_axi_arready;

    // The regfile updates with non-blocking writes, so a read sampled on a
    // commit edge sees the pre-write value.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        if (addr_hit(s_axi_araddr)) begin
                            s_axi_rdata <= rf_rd_data;
                            s_axi_rresp <= OKAY_R;
                        end else begin
                            s_axi_rdata <= '0;
                            s_axi_rresp <= SLVERR_R;
                        end
                        rd_state <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= R_IDLE;
                    end
                end
            endcase
        end
    end

    axil_byte_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk_sys (s_axi_aclk),
        .rst_b   (s_axi_aresetn),
        .wr_en   (commit && commit_hit),
        .wr_idx  (addr_idx(aw_addr_q)),
        .wr_data (w_data_q),
        .wr_strb (w_strb_q),
        .rd_idx  (rd_idx),
        .rd_data (rf_rd_data)
    );

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave with BASE_ADDR=0x10,
// eight 32-bit registers.
module tb_axil_reg_slave;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESP_WIDTH (3),
        .NUM_REGS   (8),
        .BASE_ADDR  (8'h10)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    // Bus drivers; both are entered and left on a falling edge.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                             output logic [2:0] r, output bit ok);
        bit aw_go, w_go;
        ok = 1'b0;
        r  = 3'b111;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            if (bvalid) begin
                r  = bresp;
                ok = 1'b1;
            end
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            if (ok) break;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r,
                            output bit ok);
        bit ar_go;
        ok = 1'b0;
        d  = 32'hxxxx_xxxx;
        r  = 3'b111;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ar_go = arvalid && arready;
            if (rvalid) begin
                d  = rdata;
                r  = rresp;
                ok = 1'b1;
            end
            @(negedge clk);
            if (ar_go) arvalid = 1'b0;
            if (ok) break;
        end
        arvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({awready, wready, arready} !== 3'b000) begin failures++; $display("FAIL reset_ready: got %b want 000", {awready, wready, arready}); end
        checks++; if ({bvalid, rvalid} !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b want 00", {bvalid, rvalid}); end
        checks++; if ({bresp, rresp, rdata} !== 38'd0) begin failures++; $display("FAIL reset_data: bresp=%0d rresp=%0d rdata=%h want 0", bresp, rresp, rdata); end
        aresetn = 1'b1;
        #1;
        checks++; if ({awready, wready, arready} !== 3'b000) begin failures++; $display("FAIL ready_before_edge: got %b want 000", {awready, wready, arready}); end
        @(negedge clk);
        checks++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL ready_after_edge: got %b want 111", {awready, wready, arready}); end
    endtask

    task automatic test_same_cycle();
        awaddr = 8'h14; awvalid = 1'b1; wdata = 32'd37; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if ({awready, wready, bvalid} !== 3'b000) begin failures++; $display("FAIL sc_after_hs: aw/w/b got %b want 000", {awready, wready, bvalid}); end
        @(negedge clk);
        checks++; if (bvalid !== 1'b1 || bresp !== 3'd0) begin failures++; $display("FAIL sc_bvalid: bvalid=%b bresp=%0d want 1/0", bvalid, bresp); end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++; if ({bvalid, awready, wready} !== 3'b011) begin failures++; $display("FAIL sc_b_done: b/aw/w got %b want 011", {bvalid, awready, wready}); end
        araddr = 8'h14; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'd37 || rresp !== 3'd0) begin failures++; $display("FAIL sc_read: rvalid=%b rdata=%0d rresp=%0d want 1/37/0", rvalid, rdata, rresp); end
        checks++; if (arready !== 1'b0) begin failures++; $display("FAIL sc_arready_low: got %b want 0", arready); end
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'd37) begin failures++; $display("FAIL sc_read_hold: rvalid=%b rdata=%0d want 1/37", rvalid, rdata); end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++; if ({rvalid, arready} !== 2'b01) begin failures++; $display("FAIL sc_r_done: r/ar got %b want 01", {rvalid, arready}); end
    endtask

    task automatic test_decoupled();
        logic [31:0] d;
        logic [2:0]  r;
        bit          ok;
        wdata = 32'hAABBCCDD; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL dc_wready_drop: got %b want 0", wready); end
        repeat (2) @(negedge clk);
        checks++; if ({awready, wready, bvalid} !== 3'b100) begin failures++; $display("FAIL dc_waiting_aw: aw/w/b got %b want 100", {awready, wready, bvalid}); end
        awaddr = 8'h10; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL dc_no_early_b: got %b want 0", bvalid); end
        @(negedge clk);
        checks++; if (bvalid !== 1'b1 || bresp !== 3'd0) begin failures++; $display("FAIL dc_bvalid: bvalid=%b bresp=%0d want 1/0", bvalid, bresp); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bvalid, bresp, wready, awready} !== 6'b1_000_00) begin failures++; $display("FAIL dc_b_stall%0d: b=%b resp=%0d w=%b aw=%b want 1/0/0/0", i, bvalid, bresp, wready, awready); end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++; if ({bvalid, wready} !== 2'b01) begin failures++; $display("FAIL dc_b_done: b/w got %b want 01", {bvalid, wready}); end
        axi_read(8'h10, d, r, ok);
        checks++; if (!ok || d !== 32'hAABBCCDD || r !== 3'd0) begin failures++; $display("FAIL dc_readback: ok=%b rdata=%h rresp=%0d want 1/aabbccdd/0", ok, d, r); end
    endtask

    task automatic test_partial_strobes();
        logic [31:0] d;
        logic [2:0]  r;
        bit          ok;
        axi_write(8'h18, 32'h11223344, 5'h05, r, ok);
        checks++; if (!ok || r !== 3'd0) begin failures++; $display("FAIL ps_bresp: ok=%b bresp=%0d want 1/0", ok, r); end
        axi_read(8'h18, d, r, ok);
        checks++; if (!ok || d !== 32'h00220044) begin failures++; $display("FAIL ps_strobe05: ok=%b rdata=%h want 00220044", ok, d); end
        axi_write(8'h18, 32'hFFFFFFFF, 5'h00, r, ok);
        checks++; if (!ok || r !== 3'd0) begin failures++; $display("FAIL ps_zero_bresp: ok=%b bresp=%0d want 1/0", ok, r); end
        axi_write(8'h18, 32'h99999999, 5'h10, r, ok);
        axi_read(8'h18, d, r, ok);
        checks++; if (!ok || d !== 32'h00220044) begin failures++; $display("FAIL ps_no_lanes: ok=%b rdata=%h want 00220044", ok, d); end
        axi_write(8'h1B, 32'h55000000, 5'h08, r, ok);
        axi_read(8'h18, d, r, ok);
        checks++; if (!ok || d !== 32'h55220044) begin failures++; $display("FAIL ps_unaligned: ok=%b rdata=%h want 55220044", ok, d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [2:0]  r;
        bit          ok;
        axi_write(8'h30, 32'hDEADBEEF, 5'h0F, r, ok);
        checks++; if (!ok || r !== 3'd2) begin failures++; $display("FAIL oor_wr_above: ok=%b bresp=%0d want 1/2", ok, r); end
        axi_read(8'h10, d, r, ok);
        checks++; if (!ok || d !== 32'hAABBCCDD) begin failures++; $display("FAIL oor_no_alias0: ok=%b rdata=%h want aabbccdd", ok, d); end
        axi_write(8'h04, 32'h12345678, 5'h0F, r, ok);
        checks++; if (!ok || r !== 3'd2) begin failures++; $display("FAIL oor_wr_below: ok=%b bresp=%0d want 1/2", ok, r); end
        axi_read(8'h24, d, r, ok);
        checks++; if (!ok || d !== 32'h0 || r !== 3'd0) begin failures++; $display("FAIL oor_no_alias5: ok=%b rdata=%h rresp=%0d want 0/0", ok, d, r); end
        axi_read(8'h04, d, r, ok);
        checks++; if (!ok || d !== 32'h0 || r !== 3'd2) begin failures++; $display("FAIL oor_rd_04: ok=%b rdata=%h rresp=%0d want 0/2", ok, d, r); end
        axi_read(8'h0F, d, r, ok);
        checks++; if (!ok || d !== 32'h0 || r !== 3'd2) begin failures++; $display("FAIL oor_rd_0f: ok=%b rdata=%h rresp=%0d want 0/2", ok, d, r); end
        axi_read(8'h30, d, r, ok);
        checks++; if (!ok || d !== 32'h0 || r !== 3'd2) begin failures++; $display("FAIL oor_rd_30: ok=%b rdata=%h rresp=%0d want 0/2", ok, d, r); end
        axi_read(8'h2C, d, r, ok);
        checks++; if (!ok || d !== 32'h0 || r !== 3'd0) begin failures++; $display("FAIL oor_rd_last: ok=%b rdata=%h rresp=%0d want 0/0", ok, d, r); end
    endtask

    task automatic test_hazard();
        logic [31:0] d;
        logic [2:0]  r;
        bit          ok;
        axi_write(8'h1C, 32'd5, 5'h0F, r, ok);
        checks++; if (!ok || r !== 3'd0) begin failures++; $display("FAIL hz_setup: ok=%b bresp=%0d want 1/0", ok, r); end
        awaddr = 8'h1C; awvalid = 1'b1; wdata = 32'd9; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h1C; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        checks++; if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'd5) begin failures++; $display("FAIL hz_pre_write: r/b=%b rdata=%0d want 11/5", {rvalid, bvalid}, rdata); end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        axi_read(8'h1C, d, r, ok);
        checks++; if (!ok || d !== 32'd9) begin failures++; $display("FAIL hz_post_write: ok=%b rdata=%0d want 9", ok, d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [2:0]  r;
        bit          ok;
        awaddr = 8'h14; awvalid = 1'b1; wdata = 32'h77; wstrb = 5'h0F; wvalid = 1'b1; bready = 1'b0;
        araddr = 8'h10; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        checks++; if ({bvalid, rvalid} !== 2'b11) begin failures++; $display("FAIL rm_pending: b/r got %b want 11", {bvalid, rvalid}); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({bvalid, rvalid} !== 2'b00 || rdata !== 32'h0) begin failures++; $display("FAIL rm_async_drop: b/r=%b rdata=%h want 00/0", {bvalid, rvalid}, rdata); end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1;
        checks++; if ({awready, wready, arready} !== 3'b000) begin failures++; $display("FAIL rm_ready_release: got %b want 000", {awready, wready, arready}); end
        @(negedge clk);
        checks++; if ({awready, wready, arready, bvalid} !== 4'b1110) begin failures++; $display("FAIL rm_ready_edge: aw/w/ar/b got %b want 1110", {awready, wready, arready, bvalid}); end
        for (int i = 0; i < 8; i++) begin
            axi_read(8'(8'h10 + 4 * i), d, r, ok);
            checks++; if (!ok || d !== 32'h0 || r !== 3'd0) begin failures++; $display("FAIL rm_cleared%0d: ok=%b rdata=%h rresp=%0d want 0/0", i, ok, d, r); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_same_cycle();
        test_decoupled();
        test_partial_strobes();
        test_out_of_range();
        test_hazard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI4-Lite slave register bank that sits directly downstream of the interconnect's m1/m2 master ports and terminates their transactions. It holds NUM_REGS word registers with byte-strobe writes and registered reads, and answers out-of-range addresses with SLVERR. The interconnect instantiates one copy per decoded region, each with its own BASE_ADDR.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 8, byte address width
RESP_WIDTH, 3, response field width; codes are zero-extended into it
NUM_REGS, 8, number of DATA_WIDTH-wide registers (power of 2, at least 2)
BASE_ADDR, 0, byte address of register 0; region size is NUM_REGS*DATA_WIDTH/8 bytes

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte lane i; MSB ignored
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Clock and reset: single clock s_axi_aclk. s_axi_aresetn is asynchronous and active-low.
- Reset values: all registers are 0. All outputs are 0: awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata. Ready signals rise on the first clock edge after reset release.
- All outputs are registered.
- Address decode:
  - offset = addr - BASE_ADDR.
  - The address is in range iff addr >= BASE_ADDR and offset < NUM_REGS*DATA_WIDTH/8.
  - index = offset >> log2(DATA_WIDTH/8). The low byte-offset bits are ignored, so unaligned accesses act on the containing word.
- Response codes: OKAY = 0, SLVERR = 2.
- Write path, FSM W_ACCEPT / W_RESP:
  - W_ACCEPT: the AW and W channels are captured independently into aw_held and w_held holding registers.
    - awready = !aw_held.
    - wready = !w_held.
    - A channel whose handshake has completed deasserts its ready on the next edge.
  - Commit: once both are held (they may arrive at the same edge or at different edges, in either order), the commit happens on the next edge. Same-edge AW+W handshake at edge N gives commit and bvalid=1 at edge N+1.
    - In range: byte lane i is written iff wstrb[i]. wstrb = 0 writes nothing and still returns OKAY.
    - Out of range: no register changes; bresp = SLVERR.
    - The FSM enters W_RESP and clears aw_held/w_held.
  - W_RESP: awready = wready = 0. bvalid and bresp stay stable until bready. On the edge where the B handshake completes, bvalid goes to 0, the FSM returns to W_ACCEPT and awready/wready = 1.
- Read path, FSM R_IDLE / R_DATA:
  - R_IDLE: arready = 1. An AR handshake at edge N loads rdata, rresp and rvalid=1 at edge N; they are visible in the cycle after N, giving 1-cycle latency. arready goes to 0.
    - In range: rdata = register value.
    - Out of range: rdata = 0 and rresp = SLVERR.
  - R_DATA: rdata and rresp are held stable until rready. At the handshake edge, rvalid goes to 0 and arready goes to 1 (one bubble cycle between reads).
- Simultaneous events:
  - Read and write channels operate fully concurrently.
  - When a read sample and a write commit hit the same register at the same edge, the read returns the pre-write value.
  - bready or rready asserted before valid has no effect.
- Reset mid-operation: held AW/W, pending B and pending R are discarded. valids drop immediately (asynchronously). Registers return to 0.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR constants
  - write FSM state type, read FSM state type
  - a clog2-based index-width function
- One sub-module, axil_byte_regfile:
  - NUM_REGS x DATA_WIDTH storage with asynchronous clear
  - one strobe-masked write port
  - one combinational read port
- The AXI FSMs and address decode live in axil_reg_slave.

Test Plan:
1. Same-cycle write, then read: BASE_ADDR=0x10, AW+W at addr 20 (0x14), wdata=37, wstrb=0x0F → bvalid 1 cycle later with bresp=0; a read of addr 0x14 returns rdata=37, rresp=0.
2. Decoupled channels with backpressure: W first (0xAABBCCDD, strobe 0x0F), AW 3 cycles later at 0x10, bready held low 4 cycles → bvalid and bresp stay stable; wready stays 0 until the B handshake; a readback returns 0xAABBCCDD.
3. Partial strobes: write 0x11223344 with wstrb=0x05 to a register holding 0 → readback 0x00220044; wstrb=0 → OKAY and the value is unchanged.
4. Out of range: write to addr 0x30 and read from 0x04 (BASE_ADDR=0x10, NUM_REGS=8) → bresp=2 with no register changed; rresp=2 with rdata=0.
5. Concurrency hazard: a register holds 5; a read and a write of 9 to it commit on the same edge → read returns 5, and the next read returns 9.
6. Reset mid-operation: assert aresetn=0 while bvalid=1 and rvalid=1 → both drop immediately, all registers read 0 after release, and readies return 1 one edge after release.
